change_dispenser: RTL and testbench

//  Downstream stage of the vending-machine FSM. It takes the leftover credit the FSM reports

---
 rtl/vend_pkg.sv | 34 +++
 rtl/change_dispenser_coin_select.sv | 33 +++
 rtl/change_dispenser.sv | 176 +++++++++++++++++
 tb/tb_change_dispenser.sv | 354 +++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/vend_pkg.sv
// Shared vending-machine definitions: coin denominations, drink codes and the
// change dispenser state encoding.
package vend_pkg;

    localparam int COIN_1    = 1;
    localparam int COIN_5    = 5;
    localparam int COIN_10   = 10;
    localparam int COIN_50   = 50;
    localparam int NUM_DENOM = 4;

    typedef enum logic [2:0] {
        TEA    = 3'b100,
        COKE   = 3'b101,
        COFFEE = 3'b110,
        MILK   = 3'b111
    } drink_t;

    typedef enum logic [1:0] {
        IDLE,
        DISPENSE,
        DONE
    } disp_state_t;

    // Denomination index 0..3 maps smallest to largest coin.
    function automatic int denom_value(input int idx);
        case (idx)
            0:       return COIN_1;
            1:       return COIN_5;
            2:       return COIN_10;
            default: return COIN_50;
        endcase
    endfunction

endpackage

// File: rtl/change_dispenser_coin_select.sv
// Combinational greedy picker: largest available denomination not exceeding
// the amount; none_fit when no denomination qualifies.
module coin_select
    import vend_pkg::*;
#(
    parameter int AMT_W  = 8,
    parameter int COIN_W = 6
) (
    input  logic [AMT_W-1:0]     amount,
    input  logic [NUM_DENOM-1:0] avail,
    output logic [COIN_W-1:0]    coin,
    output logic                 none_fit
);

    logic [NUM_DENOM-1:0] fit;

    for (genvar gi = 0; gi < NUM_DENOM; gi++) begin : g_fit
        assign fit[gi] = avail[gi] && (amount >= AMT_W'(denom_value(gi)));
    end

    // Ascending scan so the largest fitting denomination is the last one written.
    always_comb begin
        coin     = '0;
        none_fit = 1'b1;
        for (int i = 0; i < NUM_DENOM; i++) begin
            if (fit[i]) begin
                coin     = COIN_W'(denom_value(i));
                none_fit = 1'b0;
            end
        end
    end

endmodule

// File: rtl/change_dispenser.sv
// Pays a refund out as coins to a hopper, one coin per handshake, greedily.
// Optional per-denomination stock tracking is enabled by defining COIN_STOCK_EN.
module change_dispenser
    import vend_pkg::*;
#(
    parameter int AMT_W      = 8,
    parameter int COIN_W     = 6,
    parameter int STOCK_W    = 8,
    parameter int STOCK_INIT = 20
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              change_valid,
    input  logic [AMT_W-1:0]  change_amount,
    output logic              change_ready,
    output logic [COIN_W-1:0] coin_out,
    output logic              coin_valid,
    input  logic              hopper_ready,
    output logic              done,
    output logic              shortfall,
    output logic [AMT_W-1:0]  short_amount,
    input  logic              stock_refill
);

`ifdef COIN_STOCK_EN
    localparam bit STOCK_EN = 1'b1;
`else
    localparam bit STOCK_EN = 1'b0;
`endif

    disp_state_t          state_q, state_d;
    logic [AMT_W-1:0]     remaining_q, remaining_d;
    logic [COIN_W-1:0]    coin_out_q, coin_out_d;
    logic                 coin_valid_q, coin_valid_d;
    logic                 done_q, done_d;
    logic                 shortfall_q, shortfall_d;
    logic [AMT_W-1:0]     short_amount_q, short_amount_d;

    logic                 handshake;
    logic [AMT_W-1:0]     rem_after;
    logic [AMT_W-1:0]     sel_amount;
    logic [COIN_W-1:0]    sel_coin;
    logic                 sel_none_fit;
    logic [NUM_DENOM-1:0] avail;

    assign handshake  = coin_valid_q && hopper_ready;
    assign rem_after  = remaining_q - AMT_W'(coin_out_q);
    assign sel_amount = (state_q == IDLE) ? change_amount : rem_after;

`ifdef COIN_STOCK_EN
    // Availability looks at the post-update count so the coin re-selected in
    // the handshake edge already respects the decrement (or a refill).
    for (genvar gi = 0; gi < NUM_DENOM; gi++) begin : g_stock
        logic [STOCK_W-1:0] stock_q, stock_d;

        always_comb begin
            stock_d = stock_q;
            if (stock_refill) begin
                stock_d = STOCK_W'(STOCK_INIT);
            end else if (handshake && (coin_out_q == COIN_W'(denom_value(gi)))
                         && (stock_q != '0)) begin
                stock_d = stock_q - 1'b1;
            end
        end

        always_ff @(posedge clk or posedge reset) begin
            if (reset) begin
                stock_q <= STOCK_W'(STOCK_INIT);
            end else begin
                stock_q <= stock_d;
            end
        end

        assign avail[gi] = (stock_d != '0);
    end
`else
    logic unused_stock_refill;
    assign unused_stock_refill = stock_refill;
    assign avail = '1;
`endif

    coin_select #(
        .AMT_W  (AMT_W),
        .COIN_W (COIN_W)
    ) u_coin_select (
        .amount   (sel_amount),
        .avail    (avail),
        .coin     (sel_coin),
        .none_fit (sel_none_fit)
    );

    always_comb begin
        state_d        = state_q;
        remaining_d    = remaining_q;
        coin_out_d     = coin_out_q;
        coin_valid_d   = coin_valid_q;
        done_d         = 1'b0;
        shortfall_d    = shortfall_q;
        short_amount_d = short_amount_q;

        case (state_q)
            IDLE: begin
                if (change_valid) begin
                    remaining_d    = change_amount;
                    shortfall_d    = 1'b0;
                    short_amount_d = '0;
                    if (change_amount == '0) begin
                        state_d = DONE;
                        done_d  = 1'b1;
                    end else if (sel_none_fit) begin
                        // Every denomination exhausted before the first coin.
                        state_d        = DONE;
                        done_d         = 1'b1;
                        shortfall_d    = STOCK_EN;
                        short_amount_d = STOCK_EN ? change_amount : '0;
                    end else begin
                        state_d      = DISPENSE;
                        coin_out_d   = sel_coin;
                        coin_valid_d = 1'b1;
                    end
                end
            end
            DISPENSE: begin
                if (handshake) begin
                    remaining_d = rem_after;
                    if (rem_after == '0 || sel_none_fit) begin
                        state_d        = DONE;
                        done_d         = 1'b1;
                        coin_out_d     = '0;
                        coin_valid_d   = 1'b0;
                        shortfall_d    = STOCK_EN && (rem_after != '0);
                        short_amount_d = shortfall_d ? rem_after : '0;
                    end else begin
                        coin_out_d = sel_coin;
                    end
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d      = IDLE;
                coin_out_d   = '0;
                coin_valid_d = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q        <= IDLE;
            remaining_q    <= '0;
            coin_out_q     <= '0;
            coin_valid_q   <= 1'b0;
            done_q         <= 1'b0;
            shortfall_q    <= 1'b0;
            short_amount_q <= '0;
        end else begin
            state_q        <= state_d;
            remaining_q    <= remaining_d;
            coin_out_q     <= coin_out_d;
            coin_valid_q   <= coin_valid_d;
            done_q         <= done_d;
            shortfall_q    <= shortfall_d;
            short_amount_q <= short_amount_d;
        end
    end

    assign change_ready = (state_q == IDLE);
    assign coin_out     = coin_out_q;
    assign coin_valid   = coin_valid_q;
    assign done         = done_q;
    assign shortfall    = shortfall_q;
    assign short_amount = short_amount_q;

endmodule

// File: tb/tb_change_dispenser.sv
// Directed bench for change_dispenser; define COIN_STOCK_EN to exercise the stock build.
module tb_change_dispenser;

`ifdef COIN_STOCK_EN
    localparam int TB_STOCK_INIT = 1;
`else
    localparam int TB_STOCK_INIT = 20;
`endif

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       change_valid = 1'b0;
    logic [7:0] change_amount = '0;
    logic       change_ready;
    logic [5:0] coin_out;
    logic       coin_valid;
    logic       hopper_ready = 1'b0;
    logic       done;
    logic       shortfall;
    logic [7:0] short_amount;
    logic       stock_refill = 1'b0;

    int checks = 0;
    int failures = 0;

    always #5 clk = ~clk;

    change_dispenser #(
        .AMT_W      (8),
        .COIN_W     (6),
        .STOCK_W    (8),
        .STOCK_INIT (TB_STOCK_INIT)
    ) dut (
        .clk           (clk),
        .reset         (reset),
        .change_valid  (change_valid),
        .change_amount (change_amount),
        .change_ready  (change_ready),
        .coin_out      (coin_out),
        .coin_valid    (coin_valid),
        .hopper_ready  (hopper_ready),
        .done          (done),
        .shortfall     (shortfall),
        .short_amount  (short_amount),
        .stock_refill  (stock_refill)
    );

    // Waits (bounded) for change_ready, presents amt for one edge; returns at accept edge + 1.
    task automatic request(input logic [7:0] amt, input logic refill);
        int n = 0;
        @(negedge clk);
        while (!change_ready && n < 20) begin
            @(negedge clk);
            n++;
        end
        checks++;
        if (change_ready !== 1'b1) begin
            failures++;
            $display("FAIL req_ready amt=%0d got=%b want=1", amt, change_ready);
        end
        change_valid  = 1'b1;
        change_amount = amt;
        stock_refill  = refill;
        @(posedge clk);
        #1;
        change_valid = 1'b0;
        stock_refill = 1'b0;
        $display("request amount=%0d accepted", amt);
    endtask

    task automatic test_reset;
        reset = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        checks++;
        if ({change_ready, coin_valid, coin_out, done, shortfall, short_amount} !== {1'b1, 1'b0, 6'd0, 1'b0, 1'b0, 8'd0}) begin
            failures++;
            $display("FAIL reset_vals got ready=%b cv=%b coin=%0d done=%b sf=%b sa=%0d want 1 0 0 0 0 0",
                     change_ready, coin_valid, coin_out, done, shortfall, short_amount);
        end
        @(negedge clk);
        reset = 1'b0;
        @(posedge clk);
        #1;
        checks++;
        if (change_ready !== 1'b1 || coin_valid !== 1'b0 || done !== 1'b0) begin
            failures++;
            $display("FAIL post_reset got ready=%b cv=%b done=%b want 1 0 0", change_ready, coin_valid, done);
        end
        $display("reset done");
    endtask

    task automatic test_greedy;
        logic [5:0] exp [6] = '{6'd10, 6'd10, 6'd10, 6'd5, 6'd1, 6'd1};
        hopper_ready = 1'b1;
        request(8'd37, 1'b1);
        for (int i = 0; i < 6; i++) begin
            checks++;
            if (coin_valid !== 1'b1 || coin_out !== exp[i]) begin
                failures++;
                $display("FAIL greedy_coin%0d got cv=%b coin=%0d want cv=1 coin=%0d", i, coin_valid, coin_out, exp[i]);
            end
            $display("greedy coin %0d = %0d", i, coin_out);
            @(posedge clk);
            #1;
        end
        checks++;
        if (done !== 1'b1 || coin_valid !== 1'b0 || coin_out !== 6'd0 || change_ready !== 1'b0) begin
            failures++;
            $display("FAIL greedy_done got done=%b cv=%b coin=%0d ready=%b want 1 0 0 0", done, coin_valid, coin_out, change_ready);
        end
        @(posedge clk);
        #1;
        checks++;
        if (done !== 1'b0 || change_ready !== 1'b1) begin
            failures++;
            $display("FAIL greedy_idle got done=%b ready=%b want 0 1", done, change_ready);
        end
    endtask

    task automatic test_stall;
        logic [5:0] exp [3] = '{6'd10, 6'd5, 6'd1};
        hopper_ready = 1'b0;
        request(8'd66, 1'b1);
        for (int i = 0; i < 4; i++) begin
            checks++;
            if (coin_valid !== 1'b1 || coin_out !== 6'd50 || dut.remaining_q !== 8'd66) begin
                failures++;
                $display("FAIL stall_hold%0d got cv=%b coin=%0d rem=%0d want 1 50 66", i, coin_valid, coin_out, dut.remaining_q);
            end
            if (i < 3) begin
                @(posedge clk);
                #1;
            end
        end
        hopper_ready = 1'b1;
        $display("stall released coin=50");
        for (int i = 0; i < 3; i++) begin
            @(posedge clk);
            #1;
            checks++;
            if (coin_valid !== 1'b1 || coin_out !== exp[i]) begin
                failures++;
                $display("FAIL stall_coin%0d got cv=%b coin=%0d want 1 %0d", i, coin_valid, coin_out, exp[i]);
            end
            $display("stall coin = %0d", coin_out);
        end
        @(posedge clk);
        #1;
        checks++;
        if (done !== 1'b1 || coin_valid !== 1'b0) begin
            failures++;
            $display("FAIL stall_done got done=%b cv=%b want 1 0", done, coin_valid);
        end
    endtask

    task automatic test_zero;
        hopper_ready = 1'b1;
        request(8'd0, 1'b1);
        checks++;
        if (done !== 1'b1 || coin_valid !== 1'b0 || change_ready !== 1'b0) begin
            failures++;
            $display("FAIL zero_done got done=%b cv=%b ready=%b want 1 0 0", done, coin_valid, change_ready);
        end
        @(posedge clk);
        #1;
        checks++;
        if (done !== 1'b0 || coin_valid !== 1'b0 || change_ready !== 1'b1) begin
            failures++;
            $display("FAIL zero_idle got done=%b cv=%b ready=%b want 0 0 1", done, coin_valid, change_ready);
        end
        $display("zero request complete");
    endtask

    task automatic test_reset_mid;
        logic [5:0] exp_a [3] = '{6'd50, 6'd50, 6'd10};
        logic [5:0] exp_b [3] = '{6'd5, 6'd1, 6'd1};
        hopper_ready = 1'b1;
        request(8'd120, 1'b1);
        for (int i = 0; i < 3; i++) begin
            checks++;
            if (coin_valid !== 1'b1 || coin_out !== exp_a[i]) begin
                failures++;
                $display("FAIL mid_coin%0d got cv=%b coin=%0d want 1 %0d", i, coin_valid, coin_out, exp_a[i]);
            end
            if (i < 2) begin
                @(posedge clk);
                #1;
            end
        end
        #1;
        reset = 1'b1;
        #1;
        checks++;
        if ({change_ready, coin_valid, coin_out, done, shortfall, short_amount} !== {1'b1, 1'b0, 6'd0, 1'b0, 1'b0, 8'd0}
            || dut.remaining_q !== 8'd0) begin
            failures++;
            $display("FAIL mid_reset got ready=%b cv=%b coin=%0d done=%b rem=%0d want 1 0 0 0 0",
                     change_ready, coin_valid, coin_out, done, dut.remaining_q);
        end
        $display("mid-payout reset applied");
        @(negedge clk);
        reset = 1'b0;
        request(8'd7, 1'b1);
        for (int i = 0; i < 3; i++) begin
            checks++;
            if (coin_valid !== 1'b1 || coin_out !== exp_b[i]) begin
                failures++;
                $display("FAIL mid_new%0d got cv=%b coin=%0d want 1 %0d", i, coin_valid, coin_out, exp_b[i]);
            end
            @(posedge clk);
            #1;
        end
        checks++;
        if (done !== 1'b1) begin
            failures++;
            $display("FAIL mid_new_done got=%b want=1", done);
        end
    endtask

    task automatic test_ignore_busy;
        hopper_ready = 1'b1;
        request(8'd15, 1'b1);
        checks++;
        if (coin_out !== 6'd10 || coin_valid !== 1'b1) begin
            failures++;
            $display("FAIL busy_coin0 got cv=%b coin=%0d want 1 10", coin_valid, coin_out);
        end
        @(negedge clk);
        change_valid  = 1'b1;
        change_amount = 8'd99;
        @(posedge clk);
        #1;
        change_valid = 1'b0;
        checks++;
        if (coin_out !== 6'd5 || coin_valid !== 1'b1) begin
            failures++;
            $display("FAIL busy_coin1 got cv=%b coin=%0d want 1 5", coin_valid, coin_out);
        end
        @(posedge clk);
        #1;
        checks++;
        if (done !== 1'b1 || coin_valid !== 1'b0) begin
            failures++;
            $display("FAIL busy_done got done=%b cv=%b want 1 0", done, coin_valid);
        end
        for (int i = 0; i < 3; i++) begin
            @(posedge clk);
            #1;
            checks++;
            if (coin_valid !== 1'b0 || change_ready !== 1'b1) begin
                failures++;
                $display("FAIL busy_quiet%0d got cv=%b ready=%b want 0 1", i, coin_valid, change_ready);
            end
        end
        $display("busy request 99 ignored");
    endtask

`ifdef COIN_STOCK_EN
    task automatic test_stock;
        logic [5:0] exp [3] = '{6'd10, 6'd5, 6'd1};
        hopper_ready = 1'b1;
        reset = 1'b1;
        @(posedge clk);
        #1;
        @(negedge clk);
        reset = 1'b0;
        request(8'd37, 1'b0);
        for (int i = 0; i < 3; i++) begin
            checks++;
            if (coin_valid !== 1'b1 || coin_out !== exp[i]) begin
                failures++;
                $display("FAIL stock_coin%0d got cv=%b coin=%0d want 1 %0d", i, coin_valid, coin_out, exp[i]);
            end
            @(posedge clk);
            #1;
        end
        checks++;
        if (done !== 1'b1 || shortfall !== 1'b1 || short_amount !== 8'd21 || coin_valid !== 1'b0) begin
            failures++;
            $display("FAIL stock_short got done=%b sf=%b sa=%0d cv=%b want 1 1 21 0", done, shortfall, short_amount, coin_valid);
        end
        $display("stock shortfall amount=%0d", short_amount);
        @(posedge clk);
        #1;
        checks++;
        if (shortfall !== 1'b1 || short_amount !== 8'd21 || done !== 1'b0) begin
            failures++;
            $display("FAIL stock_hold got sf=%b sa=%0d done=%b want 1 21 0", shortfall, short_amount, done);
        end
        @(negedge clk);
        stock_refill = 1'b1;
        @(negedge clk);
        stock_refill = 1'b0;
        request(8'd6, 1'b0);
        checks++;
        if (coin_out !== 6'd5 || coin_valid !== 1'b1 || shortfall !== 1'b0) begin
            failures++;
            $display("FAIL refill_coin0 got coin=%0d cv=%b sf=%b want 5 1 0", coin_out, coin_valid, shortfall);
        end
        @(posedge clk);
        #1;
        checks++;
        if (coin_out !== 6'd1 || coin_valid !== 1'b1) begin
            failures++;
            $display("FAIL refill_coin1 got coin=%0d cv=%b want 1 1", coin_out, coin_valid);
        end
        @(posedge clk);
        #1;
        checks++;
        if (done !== 1'b1 || shortfall !== 1'b0) begin
            failures++;
            $display("FAIL refill_done got done=%b sf=%b want 1 0", done, shortfall);
        end
    endtask
`else
    task automatic test_no_stock;
        hopper_ready = 1'b1;
        request(8'd3, 1'b1);
        for (int i = 0; i < 3; i++) begin
            checks++;
            if (coin_valid !== 1'b1 || coin_out !== 6'd1) begin
                failures++;
                $display("FAIL nostock_coin%0d got cv=%b coin=%0d want 1 1", i, coin_valid, coin_out);
            end
            @(posedge clk);
            #1;
        end
        checks++;
        if (done !== 1'b1 || shortfall !== 1'b0 || short_amount !== 8'd0) begin
            failures++;
            $display("FAIL nostock_done got done=%b sf=%b sa=%0d want 1 0 0", done, shortfall, short_amount);
        end
        $display("no-stock payout of 3 complete");
    endtask
`endif

    initial begin
        test_reset();
        test_greedy();
        test_stall();
        test_zero();
        test_reset_mid();
        test_ignore_busy();
`ifdef COIN_STOCK_EN
        test_stock();
`else
        test_no_stock();
`endif
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
